bcd_timekeeper: RTL and testbench
=================================

BCD_TIMEKEEPER -- requirements
Module: bcd_timekeeper

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, input clock cycles per second (minimum 2).
REQ-002 SHALL have parameter N_ALM, default 2, number of alarm channels (1..16).
REQ-003 SHALL have parameter RING_SEC, default 60, seconds an alarm rings before auto-stop (1..255).
REQ-004 SHALL have parameter SNOOZE_MIN, default 5, snooze length in minutes (1..59).
REQ-005 SHALL use one clock and an asynchronous, active-low reset: clk input 1 bit, system clock.
REQ-006 SHALL have nCR input 1 bit, asynchronous active-low reset.
REQ-007 SHALL have mode12 input 1 bit: 1 selects 12-hour display, 0 selects 24-hour display.
REQ-008 SHALL have adj_min and adj_hr inputs, 1 bit each, single-cycle increment pulses, already debounced.
REQ-009 SHALL have alm_wr input 1 bit (write strobe), alm_sel input 4 bits (channel), and alm_hr and alm_min inputs, 8-bit BCD each.
REQ-010 SHALL have alm_en input 1 bit (enable written with the channel), snooze input 1 bit (pulse) and dismiss input 1 bit (pulse).
REQ-011 SHALL have outputs sec, min and hr, 8-bit BCD each; hr is always 24-hour.
REQ-012 SHALL have hr_disp output 8-bit BCD (display hour) and pm output 1 bit.
REQ-013 SHALL have tick output 1 bit: a one-cycle pulse per second.
REQ-014 SHALL have ring output 1 bit, ring_id output 4 bits (firing channel) and alm_err output 1 bit (one-cycle pulse).

Function
REQ-015 SHALL run a prescaler that counts 0..CLK_HZ-1 and asserts tick for exactly one cycle when it reaches CLK_HZ-1, then wraps to 0.
REQ-016 SHALL advance sec 00..59 in BCD on tick; at the 59->00 wrap, min SHALL increment in the same cycle.
REQ-017 SHALL advance min 00..59; when both sec and min wrap in the same cycle, hr SHALL step 00..23 and wrap 23->00.
REQ-018 SHALL keep every BCD nibble in 0..9 at all times, and the low nibble SHALL carry into the high nibble at 9.
REQ-019 SHALL increment min modulo 60 on adj_min, with no carry into hr; sec and the prescaler are unaffected.
REQ-020 SHALL increment hr modulo 24 on adj_hr.
REQ-021 SHALL apply a net +1 to min (never +2) when adj_min coincides with a tick carry into min; the same rule applies to adj_hr and hr.
REQ-022 SHALL map hr to hr_disp/pm combinationally when mode12=1: 00->12/0, 01..11->same/0, 12->12/1, 13..23->(hr-12)/1.
REQ-023 SHALL output hr_disp=hr and pm=(hr>=12) when mode12=0.
REQ-024 SHALL write {alm_en, alm_hr, alm_min} to channel alm_sel on alm_wr, visible from the next cycle.
REQ-025 SHALL reject an alm_wr when alm_sel>=N_ALM, any nibble >9, alm_hr>23 or alm_min>59: storage is left unchanged and alm_err pulses one cycle.
REQ-026 SHALL treat a channel as matching on a tick cycle that produces sec=00, when the channel is enabled and its hr/min equal the new hr/min; the lowest matching index wins.
REQ-027 SHALL implement a ring FSM with states IDLE, RING, SNOOZE; ring=1 only in RING.
REQ-028 SHALL go IDLE->RING on a match, latching ring_id and loading a ring counter with RING_SEC.
REQ-029 SHALL in RING decrement the ring counter per tick, returning to IDLE at 0; dismiss goes to IDLE; snooze goes to SNOOZE and loads SNOOZE_MIN*60.
REQ-030 SHALL give dismiss priority over snooze when both arrive in the same cycle.
REQ-031 SHALL in SNOOZE decrement per tick and go to RING (same ring_id, ring counter reloaded) at 0; dismiss goes to IDLE.
REQ-032 SHALL ignore new matches while in RING or SNOOZE.
REQ-033 SHALL let an alarm write to the active channel affect only future matches, not the current ring or snooze.
REQ-034 SHALL register all FSM and counter state on clk; there is no combinational path from snooze or dismiss to ring.

Reset
REQ-035 SHALL on nCR=0 immediately clear the prescaler, sec, min and hr to 00, tick=0, alm_err=0, the FSM to IDLE, ring=0, ring_id=0, and all channels to disabled with 00:00.
REQ-036 SHALL abort any ring or snooze on reset mid-operation, and SHALL require no tick on the first cycle after release.

Verification (CLK_HZ=4, N_ALM=2, RING_SEC=3, SNOOZE_MIN=1)
REQ-037 SHALL verify: preload via adj to 23:59, run 60 ticks -> 00:00:00, hr_disp=12, pm=0 with mode12=1.
REQ-038 SHALL verify: adj_min coincident with the sec 59->00 wrap at min=10 -> min=11, not 12.
REQ-039 SHALL verify: write ch1=00:01 enabled, ch0=00:01 enabled -> at 00:01:00 ring=1, ring_id=0 for 3 ticks, then IDLE.
REQ-040 SHALL verify: snooze in RING -> ring=0 for 60 ticks, then ring=1 with the same ring_id; dismiss -> IDLE.
REQ-041 SHALL verify: alm_wr with alm_hr=8'h24 or alm_sel=2 -> alm_err pulse, no match at that time.
REQ-042 SHALL verify: nCR low during RING -> ring=0 and all counters 00 asynchronously, before the next clk edge.

Source files
------------

// File: rtl/bcd_timekeeper.sv
// rtl/bcd_timekeeper.sv - BCD time-of-day clock with alarm channels, ring/snooze FSM
//
// Purpose: counts seconds/minutes/hours in packed BCD from a prescaled clock,
// supports manual minute/hour adjust, 12/24-hour display mapping, and N_ALM
// alarm channels feeding a ring/snooze state machine.
//
// Ports:
//   clk                 system clock
//   nCR                 asynchronous active-low reset
//   mode12              1 = 12-hour display, 0 = 24-hour display
//   adj_min, adj_hr     single-cycle increment pulses
//   alm_wr/alm_sel      alarm write strobe / channel select
//   alm_hr/alm_min      alarm time, BCD
//   alm_en              enable written with the channel
//   snooze, dismiss     ring control pulses
//   sec, min, hr        current time, BCD, hr in 24-hour form
//   hr_disp, pm         display hour (BCD) and PM flag
//   tick                one-cycle pulse per second
//   ring, ring_id       ringing flag and firing channel
//   alm_err             one-cycle pulse on a rejected alarm write
module bcd_timekeeper #(
  parameter int CLK_HZ     = 50000000,
  parameter int N_ALM      = 2,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_MIN = 5
) (
  input  logic       clk,
  input  logic       nCR,
  input  logic       mode12,
  input  logic       adj_min,
  input  logic       adj_hr,
  input  logic       alm_wr,
  input  logic [3:0] alm_sel,
  input  logic [7:0] alm_hr,
  input  logic [7:0] alm_min,
  input  logic       alm_en,
  input  logic       snooze,
  input  logic       dismiss,
  output logic [7:0] sec,
  output logic [7:0] min,
  output logic [7:0] hr,
  output logic [7:0] hr_disp,
  output logic       pm,
  output logic       tick,
  output logic       ring,
  output logic [3:0] ring_id,
  output logic       alm_err
);

  localparam int PW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
  // Wide enough for both RING_SEC (<=255) and SNOOZE_MIN*60 (<=3540).
  localparam int CW = 12;
  localparam logic [CW-1:0] RING_LOAD   = CW'(RING_SEC);
  localparam logic [CW-1:0] SNOOZE_LOAD = CW'(SNOOZE_MIN * 60);

  typedef enum logic [1:0] {S_IDLE, S_RING, S_SNOOZE} state_t;

  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    sec_q, sec_d, min_q, min_d, hr_q, hr_d;
  logic          sec_wrap, hr_carry;

  logic [N_ALM-1:0]      aen_q;
  logic [N_ALM-1:0][7:0] ahr_q;
  logic [N_ALM-1:0][7:0] amin_q;
  logic                  alm_err_q;
  logic                  wr_ok;

  logic          match_hit;
  logic [3:0]    match_id;
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          ring_q;
  logic [3:0]    ring_id_q;

  logic [4:0] hr_bin, h12;

  // Wraps to zero at top, otherwise carries the low nibble into the high one at 9.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
    logic [7:0] r;
    if (v == top) r = 8'h00;
    else if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
    else r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  assign tick     = (presc_q == PRESC_MAX);
  assign presc_d  = tick ? '0 : presc_q + PW'(1);
  assign sec_wrap = tick && (sec_q == 8'h59);
  // Hours only follow a minute wrap caused by the seconds carry, not by adj_min.
  assign hr_carry = sec_wrap && (min_q == 8'h59);

  // A coinciding adjust and carry both request the same single increment.
  always_comb begin
    sec_d = tick ? bcd_inc(sec_q, 8'h59) : sec_q;
    min_d = (sec_wrap || adj_min) ? bcd_inc(min_q, 8'h59) : min_q;
    hr_d  = (hr_carry || adj_hr) ? bcd_inc(hr_q, 8'h23) : hr_q;
  end

  always_ff @(posedge clk or negedge nCR) begin
    if (!nCR) begin
      presc_q <= '0;
      sec_q   <= 8'h00;
      min_q   <= 8'h00;
      hr_q    <= 8'h00;
    end else begin
      presc_q <= presc_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hr_q    <= hr_d;
    end
  end

  // Nibble checks first make the plain byte comparisons valid BCD range checks.
  always_comb begin
    wr_ok = ({28'd0, alm_sel} < 32'(N_ALM))
         && (alm_hr[7:4] <= 4'd9) && (alm_hr[3:0] <= 4'd9)
         && (alm_min[7:4] <= 4'd9) && (alm_min[3:0] <= 4'd9)
         && (alm_hr <= 8'h23) && (alm_min <= 8'h59);
  end

  always_ff @(posedge clk or negedge nCR) begin
    if (!nCR) begin
      aen_q     <= '0;
      ahr_q     <= '0;
      amin_q    <= '0;
      alm_err_q <= 1'b0;
    end else begin
      alm_err_q <= alm_wr && !wr_ok;
      for (int i = 0; i < N_ALM; i++) begin
        if (alm_wr && wr_ok && (alm_sel == 4'(i))) begin
          aen_q[i]  <= alm_en;
          ahr_q[i]  <= alm_hr;
          amin_q[i] <= alm_min;
        end
      end
    end
  end

  // Matches are judged against the time being entered at the :00 boundary;
  // scanning downward leaves the lowest matching index.
  always_comb begin
    match_hit = 1'b0;
    match_id  = 4'd0;
    for (int i = N_ALM - 1; i >= 0; i--) begin
      if (aen_q[i] && (ahr_q[i] == hr_d) && (amin_q[i] == min_d)) begin
        match_hit = 1'b1;
        match_id  = 4'(i);
      end
    end
    if (!sec_wrap) match_hit = 1'b0;
  end

  always_ff @(posedge clk or negedge nCR) begin
    if (!nCR) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      ring_q    <= 1'b0;
      ring_id_q <= 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (match_hit) begin
            state_q   <= S_RING;
            ring_q    <= 1'b1;
            cnt_q     <= RING_LOAD;
            ring_id_q <= match_id;
          end
        end
        S_RING: begin
          if (dismiss) begin
            state_q <= S_IDLE;
            ring_q  <= 1'b0;
          end else if (snooze) begin
            state_q <= S_SNOOZE;
            ring_q  <= 1'b0;
            cnt_q   <= SNOOZE_LOAD;
          end else if (tick) begin
            if (cnt_q == CW'(1)) begin
              state_q <= S_IDLE;
              ring_q  <= 1'b0;
            end
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_SNOOZE: begin
          if (dismiss) begin
            state_q <= S_IDLE;
          end else if (tick) begin
            if (cnt_q == CW'(1)) begin
              state_q <= S_RING;
              ring_q  <= 1'b1;
              cnt_q   <= RING_LOAD;
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          ring_q  <= 1'b0;
        end
      endcase
    end
  end

  // Display mapping goes through binary so 20..23 map cleanly to 08..11.
  always_comb begin
    hr_bin = ({1'b0, hr_q[7:4]} * 5'd10) + {1'b0, hr_q[3:0]};
    pm     = (hr_bin >= 5'd12);
    if (hr_bin == 5'd0) h12 = 5'd12;
    else if (hr_bin > 5'd12) h12 = hr_bin - 5'd12;
    else h12 = hr_bin;
    if (!mode12) hr_disp = hr_q;
    else if (h12 >= 5'd10) hr_disp = {4'd1, 4'(h12 - 5'd10)};
    else hr_disp = {4'd0, h12[3:0]};
  end

  assign sec     = sec_q;
  assign min     = min_q;
  assign hr      = hr_q;
  assign ring    = ring_q;
  assign ring_id = ring_id_q;
  assign alm_err = alm_err_q;

endmodule

// File: tb/tb_bcd_timekeeper.sv
// tb/tb_bcd_timekeeper.sv - randomized and directed bench for bcd_timekeeper against a seconds-of-day model
module tb_bcd_timekeeper;

  localparam int CLK_HZ     = 4;
  localparam int N_ALM      = 2;
  localparam int RING_SEC   = 3;
  localparam int SNOOZE_MIN = 1;

  logic       clk = 1'b0;
  logic       nCR, mode12, adj_min, adj_hr, alm_wr, alm_en, snooze, dismiss;
  logic [3:0] alm_sel;
  logic [7:0] alm_hr, alm_min;
  logic [7:0] sec, min, hr, hr_disp;
  logic       pm, tick, ring, alm_err;
  logic [3:0] ring_id;

  bcd_timekeeper #(
    .CLK_HZ(CLK_HZ), .N_ALM(N_ALM), .RING_SEC(RING_SEC), .SNOOZE_MIN(SNOOZE_MIN)
  ) dut (
    .clk(clk), .nCR(nCR), .mode12(mode12), .adj_min(adj_min), .adj_hr(adj_hr),
    .alm_wr(alm_wr), .alm_sel(alm_sel), .alm_hr(alm_hr), .alm_min(alm_min),
    .alm_en(alm_en), .snooze(snooze), .dismiss(dismiss),
    .sec(sec), .min(min), .hr(hr), .hr_disp(hr_disp), .pm(pm), .tick(tick),
    .ring(ring), .ring_id(ring_id), .alm_err(alm_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Model: time as seconds of day, alarms as binary hour/minute, ring state
  // as 0 idle / 1 ringing / 2 snoozing with a count of ticks remaining.
  int m_presc, m_tod, m_st, m_left, m_id;
  bit m_err;
  bit m_en [N_ALM];
  int m_ahr [N_ALM];
  int m_amin [N_ALM];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic int bcd(input int v);
    return ((v / 10) << 4) | (v % 10);
  endfunction

  function automatic bit bcd_ok(input int b, input int lim);
    int hi, lo;
    hi = (b >> 4) & 15;
    lo = b & 15;
    return (hi <= 9) && (lo <= 9) && ((hi * 10 + lo) <= lim);
  endfunction

  function automatic int from_bcd(input int b);
    return ((b >> 4) & 15) * 10 + (b & 15);
  endfunction

  task automatic model_reset();
    m_presc = 0; m_tod = 0; m_st = 0; m_left = 0; m_id = 0; m_err = 0;
    for (int i = 0; i < N_ALM; i++) begin
      m_en[i] = 0; m_ahr[i] = 0; m_amin[i] = 0;
    end
  endtask

  task automatic model_step();
    int h, m, s, hit;
    bit tk, cm, ch, ok;
    tk = (m_presc == CLK_HZ - 1);
    m_presc = tk ? 0 : m_presc + 1;
    h = m_tod / 3600; m = (m_tod / 60) % 60; s = m_tod % 60;
    cm = 0; ch = 0;
    if (tk) begin
      s++;
      if (s == 60) begin s = 0; cm = 1; end
    end
    if (cm || adj_min) begin
      m++;
      if (m == 60) begin m = 0; ch = cm; end
    end
    if (ch || adj_hr) h = (h + 1) % 24;
    m_tod = h * 3600 + m * 60 + s;
    hit = -1;
    if (cm) for (int i = N_ALM - 1; i >= 0; i--)
      if (m_en[i] && m_ahr[i] == h && m_amin[i] == m) hit = i;
    case (m_st)
      0: if (hit >= 0) begin m_st = 1; m_left = RING_SEC; m_id = hit; end
      1: if (dismiss) m_st = 0;
         else if (snooze) begin m_st = 2; m_left = SNOOZE_MIN * 60; end
         else if (tk) begin m_left--; if (m_left == 0) m_st = 0; end
      default: if (dismiss) m_st = 0;
         else if (tk) begin
           m_left--;
           if (m_left == 0) begin m_st = 1; m_left = RING_SEC; end
         end
    endcase
    ok = (int'(alm_sel) < N_ALM) && bcd_ok(int'(alm_hr), 23) && bcd_ok(int'(alm_min), 59);
    m_err = alm_wr && !ok;
    if (alm_wr && ok) begin
      m_en[alm_sel] = alm_en;
      m_ahr[alm_sel] = from_bcd(int'(alm_hr));
      m_amin[alm_sel] = from_bcd(int'(alm_min));
    end
  endtask

  task automatic model_check();
    int h, hd;
    h = m_tod / 3600;
    hd = mode12 ? ((h % 12 == 0) ? 12 : h % 12) : h;
    chk("sec", int'(sec), bcd(m_tod % 60));
    chk("min", int'(min), bcd((m_tod / 60) % 60));
    chk("hr", int'(hr), bcd(h));
    chk("hr_disp", int'(hr_disp), bcd(hd));
    chk("pm", int'(pm), int'(h >= 12));
    chk("tick", int'(tick), int'(m_presc == CLK_HZ - 1));
    chk("ring", int'(ring), int'(m_st == 1));
    chk("ring_id", int'(ring_id), m_id);
    chk("alm_err", int'(alm_err), int'(m_err));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    model_check();
    adj_min = 0; adj_hr = 0; alm_wr = 0; snooze = 0; dismiss = 0;
  endtask

  task automatic write_alm(input int sel, input int h, input int m, input bit en);
    alm_wr = 1; alm_sel = 4'(sel); alm_hr = 8'(h); alm_min = 8'(m); alm_en = en;
    cycle();
  endtask

  task automatic run_until_tod(input int target, input string name);
    int k;
    k = 0;
    while (m_tod != target && k < 2000) begin
      cycle();
      k++;
    end
    chk(name, int'(k >= 2000), 0);
  endtask

  task automatic do_reset();
    nCR = 0;
    #1;
    model_reset();
    @(negedge clk);
    nCR = 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    nCR = 1; mode12 = 1; adj_min = 0; adj_hr = 0; alm_wr = 0; alm_sel = 0;
    alm_hr = 0; alm_min = 0; alm_en = 0; snooze = 0; dismiss = 0;
    #2 nCR = 0;
    #1;
    chk("rst_sec", int'(sec), 0);
    chk("rst_min", int'(min), 0);
    chk("rst_hr", int'(hr), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_ring", int'(ring), 0);
    chk("rst_ring_id", int'(ring_id), 0);
    chk("rst_alm_err", int'(alm_err), 0);
    chk("rst_hr_disp12", int'(hr_disp), 'h12);
    model_reset();
    @(negedge clk);
    nCR = 1;
    cycle();
    chk("no_tick_after_release", int'(tick), 0);

    // Preload 23:59 by adjust pulses, then roll over midnight.
    for (int i = 0; i < 23; i++) begin adj_hr = 1; cycle(); end
    for (int i = 0; i < 59; i++) begin adj_min = 1; cycle(); end
    chk("preload_hr", int'(hr), 'h23);
    chk("preload_min", int'(min), 'h59);
    chk("preload_disp", int'(hr_disp), 'h11);
    chk("preload_pm", int'(pm), 1);
    run_until_tod(0, "wait_midnight");
    chk("midnight_sec", int'(sec), 0);
    chk("midnight_min", int'(min), 0);
    chk("midnight_hr", int'(hr), 0);
    chk("midnight_disp", int'(hr_disp), 'h12);
    chk("midnight_pm", int'(pm), 0);

    // adj_min coincident with the seconds carry gives a single increment.
    for (int i = 0; i < 10; i++) begin adj_min = 1; cycle(); end
    k = 0;
    while (!(m_presc == CLK_HZ - 1 && m_tod % 60 == 59) && k < 2000) begin cycle(); k++; end
    chk("wait_sec59", int'(k >= 2000), 0);
    adj_min = 1;
    cycle();
    chk("coincident_min", int'(min), 'h11);
    chk("coincident_sec", int'(sec), 'h00);

    // Two channels matching the same minute: lowest index rings for 3 ticks.
    do_reset();
    write_alm(1, 'h00, 'h01, 1);
    write_alm(0, 'h00, 'h01, 1);
    run_until_tod(60, "wait_0001");
    chk("ring_start", int'(ring), 1);
    chk("ring_id_low", int'(ring_id), 0);
    run_until_tod(62, "wait_ring_last");
    chk("ring_third_sec", int'(ring), 1);
    run_until_tod(63, "wait_ring_end");
    chk("ring_auto_stop", int'(ring), 0);

    // Snooze then re-ring after 60 ticks, then dismiss.
    write_alm(0, 'h00, 'h02, 1);
    run_until_tod(120, "wait_0002");
    chk("ring2_start", int'(ring), 1);
    snooze = 1;
    cycle();
    chk("snooze_quiet", int'(ring), 0);
    run_until_tod(179, "wait_snooze_end");
    chk("snooze_still_quiet", int'(ring), 0);
    run_until_tod(180, "wait_rering");
    chk("rering", int'(ring), 1);
    chk("rering_id", int'(ring_id), 0);
    dismiss = 1;
    cycle();
    chk("dismissed", int'(ring), 0);

    // Rejected writes.
    write_alm(0, 'h24, 'h05, 1);
    chk("err_hr24", int'(alm_err), 1);
    cycle();
    chk("err_clears", int'(alm_err), 0);
    write_alm(2, 'h00, 'h05, 1);
    chk("err_sel2", int'(alm_err), 1);
    write_alm(1, 'h0A, 'h05, 1);
    chk("err_nibble", int'(alm_err), 1);
    run_until_tod(300, "wait_0005");
    chk("no_match_rejected", int'(ring), 0);

    // Asynchronous reset in the middle of a ring.
    write_alm(1, 'h00, 'h06, 1);
    run_until_tod(360, "wait_0006");
    chk("ring3_start", int'(ring), 1);
    chk("ring3_id", int'(ring_id), 1);
    nCR = 0;
    #1;
    chk("async_ring", int'(ring), 0);
    chk("async_sec", int'(sec), 0);
    chk("async_min", int'(min), 0);
    chk("async_hr", int'(hr), 0);
    chk("async_id", int'(ring_id), 0);
    model_reset();
    @(negedge clk);
    nCR = 1;
    cycle();
    chk("no_tick_after_release2", int'(tick), 0);

    // Randomized traffic with alarms aimed near the current time.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 199) == 0) mode12 = ~mode12;
      adj_min = ($urandom_range(0, 199) == 0);
      adj_hr = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 39) == 0) begin
        alm_wr = 1;
        alm_sel = 4'($urandom_range(0, 2));
        alm_en = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 7) == 0) begin
          alm_hr = 8'($urandom);
          alm_min = 8'($urandom);
        end else begin
          alm_hr = 8'(bcd(m_tod / 3600));
          alm_min = 8'(bcd(((m_tod / 60) % 60 + $urandom_range(0, 2)) % 60));
        end
      end
      snooze = ($urandom_range(0, 59) == 0);
      dismiss = ($urandom_range(0, 89) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
